// File: rtl/cu_pkg.sv
// Shared types and default constants for the CPU control-unit sequencer.
package cu_pkg;

    // Sequencer top-level states.
    typedef enum logic [2:0] {
        CU_ST_INIT     = 3'd0,
        CU_ST_FETCH    = 3'd1,
        CU_ST_EXEC     = 3'd2,
        CU_ST_HALT     = 3'd3,
        CU_ST_DISPATCH = 3'd4
    } cu_state_e;

    // Default timing: T-steps per M-cycle, opcode length limit, dispatch length.
    localparam int unsigned CU_T_PER_M    = 4;
    localparam int unsigned CU_MAX_M      = 8;
    localparam int unsigned CU_DISPATCH_M = 5;

    // Default interrupt vector table layout.
    localparam int unsigned CU_VECTOR_BASE   = 32'h40;
    localparam int unsigned CU_VECTOR_STRIDE = 8;

    // Dispatch target address for interrupt index idx.
    function automatic logic [7:0] cuVector(input int unsigned base,
                                            input int unsigned stride,
                                            input int unsigned idx);
        int unsigned full;
        full = base + stride * idx;
        return full[7:0];
    endfunction

endpackage

// File: rtl/Decoder.sv
// Generic binary-to-one-hot decoder used for the T-step and M-cycle strobes.
module Decoder #(
    parameter int unsigned IN_W  = 2,
    parameter int unsigned OUT_N = 4
) (
    input  logic [IN_W-1:0]  in_i,
    output logic [OUT_N-1:0] out_o
);

    // One output bit per code; codes beyond OUT_N-1 decode to all zero.
    always_comb begin
        out_o = '0;
        for (int unsigned i = 0; i < OUT_N; i++) begin
            out_o[i] = (in_i == IN_W'(i));
        end
    end

endmodule

// File: rtl/cu_irq_priority.sv
// Lowest-index-wins priority encoder for the interrupt request lines.
module cu_irq_priority #(
    parameter int unsigned NUM_IRQ = 5,
    parameter int unsigned IDX_W   = 3
) (
    input  logic [NUM_IRQ-1:0] req_i,
    output logic [NUM_IRQ-1:0] grant_o,
    output logic [IDX_W-1:0]   index_o,
    output logic               any_o
);

    // Scan from index 0 upward; the first set request takes the grant.
    always_comb begin
        logic found;
        grant_o = '0;
        index_o = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (req_i[i] && !found) begin
                grant_o[i] = 1'b1;
                index_o    = IDX_W'(i);
                found      = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/cu_sequencer.sv
// Control-unit step sequencer: T/M strobes, fetch/prefetch, HALT, IME and
// prioritised interrupt dispatch with vector generation and overrun flag.
module cu_sequencer
    import cu_pkg::*;
#(
    parameter int unsigned T_PER_M       = CU_T_PER_M,
    parameter int unsigned MAX_M         = CU_MAX_M,
    parameter int unsigned NUM_IRQ       = 5,
    parameter int unsigned DISPATCH_M    = CU_DISPATCH_M,
    parameter int unsigned VECTOR_BASE   = CU_VECTOR_BASE,
    parameter int unsigned VECTOR_STRIDE = CU_VECTOR_STRIDE
) (
    input  logic               i_Clk,
    input  logic               i_nRst,
    input  logic               i_Enable,
    input  logic               i_End_Opcode,
    input  logic               i_Halt,
    input  logic               i_EI,
    input  logic               i_DI,
    input  logic               i_RETI,
    input  logic [NUM_IRQ-1:0] i_IRQ,
    output logic [T_PER_M-1:0] o_T_Step,
    output logic [MAX_M-1:0]   o_M_Count,
    output logic               o_Fetch,
    output logic               o_Init,
    output logic               o_Dispatch,
    output logic [NUM_IRQ-1:0] o_Irq_Ack,
    output logic [7:0]         o_Vector,
    output logic               o_IME,
    output logic               o_Halted,
    output logic               o_Overrun
);

    localparam int unsigned TW = (T_PER_M > 1) ? $clog2(T_PER_M) : 1;
    localparam int unsigned MW = (MAX_M > 1) ? $clog2(MAX_M) : 1;
    localparam int unsigned IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    if (T_PER_M < 2) begin : g_badTPerM
        $error("cu_sequencer: T_PER_M must be at least 2");
    end
    if (MAX_M < DISPATCH_M) begin : g_badMaxM
        $error("cu_sequencer: MAX_M must not be smaller than DISPATCH_M");
    end
    if (VECTOR_BASE + (NUM_IRQ - 1) * VECTOR_STRIDE > 255) begin : g_badVector
        $error("cu_sequencer: interrupt vector table exceeds 8-bit address range");
    end

    cu_state_e          state_q, state_d;
    logic [TW-1:0]      t_q, t_d;
    logic [MW-1:0]      m_q, m_d;
    logic               ime_q, ime_d;
    logic               eiPending_q, eiPending_d;
    logic               eiArm_q, eiArm_d;
    logic               endLatch_q, endLatch_d;
    logic               haltLatch_q, haltLatch_d;
    logic               overrun_q, overrun_d;
    logic [NUM_IRQ-1:0] irqAck_q, irqAck_d;
    logic [7:0]         vector_q, vector_d;

    logic [NUM_IRQ-1:0] irqGrant;
    logic [IW-1:0]      irqIdx;
    logic               irqAny;
    logic [7:0]         vectorCalc;
    logic               tLast;
    logic               mLastExec;
    logic               mLastDisp;
    logic               endNow;
    logic               haltNow;
    logic               strobesOn;
    logic [T_PER_M-1:0] tOneHot;
    logic [MAX_M-1:0]   mOneHot;

    cu_irq_priority #(
        .NUM_IRQ (NUM_IRQ),
        .IDX_W   (IW)
    ) u_irqPriority (
        .req_i   (i_IRQ),
        .grant_o (irqGrant),
        .index_o (irqIdx),
        .any_o   (irqAny)
    );

    Decoder #(
        .IN_W  (TW),
        .OUT_N (T_PER_M)
    ) u_tDecoder (
        .in_i  (t_q),
        .out_o (tOneHot)
    );

    Decoder #(
        .IN_W  (MW),
        .OUT_N (MAX_M)
    ) u_mDecoder (
        .in_i  (m_q),
        .out_o (mOneHot)
    );

    assign vectorCalc = cuVector(VECTOR_BASE, VECTOR_STRIDE, 32'(irqIdx));
    assign tLast      = (t_q == TW'(T_PER_M - 1));
    assign mLastExec  = (m_q == MW'(MAX_M - 1));
    assign mLastDisp  = (m_q == MW'(DISPATCH_M - 1));
    assign endNow     = endLatch_q | i_End_Opcode;
    assign haltNow    = haltLatch_q | i_Halt;

    // Next-state logic for the sequencer, counters, IME machinery and dispatch.
    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        m_d         = m_q;
        ime_d       = ime_q;
        eiPending_d = eiPending_q;
        eiArm_d     = eiArm_q;
        endLatch_d  = endLatch_q;
        haltLatch_d = haltLatch_q;
        overrun_d   = overrun_q;
        irqAck_d    = '0;
        vector_d    = vector_q;

        case (state_q)
            CU_ST_INIT: begin
                if (tLast) begin
                    state_d = CU_ST_FETCH;
                    t_d     = '0;
                    m_d     = '0;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end

            CU_ST_FETCH: begin
                state_d = CU_ST_EXEC;
                t_d     = '0;
                m_d     = '0;
                if (eiPending_q) begin
                    eiArm_d     = 1'b1;
                    eiPending_d = 1'b0;
                end
            end

            CU_ST_EXEC: begin
                if (i_DI) begin
                    ime_d       = 1'b0;
                    eiPending_d = 1'b0;
                    eiArm_d     = 1'b0;
                end else if (i_RETI) begin
                    ime_d = 1'b1;
                end else if (i_EI) begin
                    eiPending_d = 1'b1;
                end

                if (!tLast) begin
                    t_d         = t_q + TW'(1);
                    endLatch_d  = endNow;
                    haltLatch_d = haltNow;
                end else begin
                    t_d         = '0;
                    endLatch_d  = 1'b0;
                    haltLatch_d = 1'b0;
                    if (endNow) begin
                        if (eiArm_q && !i_DI) begin
                            ime_d   = 1'b1;
                            eiArm_d = 1'b0;
                        end
                        m_d = '0;
                        if (ime_d && irqAny) begin
                            state_d  = CU_ST_DISPATCH;
                            ime_d    = 1'b0;
                            irqAck_d = irqGrant;
                            vector_d = vectorCalc;
                        end else if (haltNow) begin
                            state_d = CU_ST_HALT;
                        end else begin
                            state_d = CU_ST_FETCH;
                        end
                    end else if (mLastExec) begin
                        overrun_d = 1'b1;
                        state_d   = CU_ST_FETCH;
                        m_d       = '0;
                    end else begin
                        m_d = m_q + MW'(1);
                    end
                end
            end

            CU_ST_HALT: begin
                t_d = '0;
                m_d = '0;
                if (irqAny) begin
                    if (ime_q) begin
                        state_d  = CU_ST_DISPATCH;
                        ime_d    = 1'b0;
                        irqAck_d = irqGrant;
                        vector_d = vectorCalc;
                    end else begin
                        state_d = CU_ST_FETCH;
                    end
                end
            end

            CU_ST_DISPATCH: begin
                if (tLast) begin
                    t_d = '0;
                    if (mLastDisp) begin
                        state_d = CU_ST_FETCH;
                        m_d     = '0;
                    end else begin
                        m_d = m_q + MW'(1);
                    end
                end else begin
                    t_d = t_q + TW'(1);
                end
            end

            default: begin
                state_d = CU_ST_INIT;
                t_d     = '0;
                m_d     = '0;
            end
        endcase
    end

    // State registers: synchronous active-low reset, otherwise advance only when enabled.
    always_ff @(posedge i_Clk) begin
        if (!i_nRst) begin
            state_q     <= CU_ST_INIT;
            t_q         <= '0;
            m_q         <= '0;
            ime_q       <= 1'b0;
            eiPending_q <= 1'b0;
            eiArm_q     <= 1'b0;
            endLatch_q  <= 1'b0;
            haltLatch_q <= 1'b0;
            overrun_q   <= 1'b0;
            irqAck_q    <= '0;
            vector_q    <= '0;
        end else if (i_Enable) begin
            state_q     <= state_d;
            t_q         <= t_d;
            m_q         <= m_d;
            ime_q       <= ime_d;
            eiPending_q <= eiPending_d;
            eiArm_q     <= eiArm_d;
            endLatch_q  <= endLatch_d;
            haltLatch_q <= haltLatch_d;
            overrun_q   <= overrun_d;
            irqAck_q    <= irqAck_d;
            vector_q    <= vector_d;
        end
    end

    assign strobesOn  = (state_q == CU_ST_INIT) || (state_q == CU_ST_EXEC) ||
                        (state_q == CU_ST_DISPATCH);
    assign o_T_Step   = strobesOn ? tOneHot : '0;
    assign o_M_Count  = strobesOn ? mOneHot : '0;
    assign o_Fetch    = (state_q == CU_ST_FETCH);
    assign o_Init     = (state_q == CU_ST_INIT);
    assign o_Dispatch = (state_q == CU_ST_DISPATCH);
    assign o_Halted   = (state_q == CU_ST_HALT);
    assign o_Irq_Ack  = irqAck_q;
    assign o_Vector   = vector_q;
    assign o_IME      = ime_q;
    assign o_Overrun  = overrun_q;

endmodule

// File: tb/tb_cu_sequencer.sv
// Self-checking bench for cu_sequencer: directed scenarios plus random
// traffic, compared each clock against a cycle-count behavioural model.
module tb_cu_sequencer;

    localparam int T     = 4;
    localparam int MAXM  = 8;
    localparam int NIRQ  = 5;
    localparam int DISPM = 5;
    localparam int VBASE = 'h40;
    localparam int VSTEP = 8;

    localparam int P_INIT  = 0;
    localparam int P_FETCH = 1;
    localparam int P_EXEC  = 2;
    localparam int P_HALT  = 3;
    localparam int P_DISP  = 4;

    logic            clk = 1'b0;
    logic            nRst;
    logic            enable;
    logic            endOpcode;
    logic            haltIn;
    logic            eiIn;
    logic            diIn;
    logic            retiIn;
    logic [NIRQ-1:0] irqIn;

    logic [T-1:0]    tStep;
    logic [MAXM-1:0] mCount;
    logic            fetch;
    logic            init;
    logic            dispatch;
    logic [NIRQ-1:0] irqAck;
    logic [7:0]      vector;
    logic            ime;
    logic            halted;
    logic            overrun;

    int testsRun    = 0;
    int testsFailed = 0;

    // Behavioural model: phase plus clocks spent in that phase.
    int              mPhase;
    int              mCyc;
    bit              mIme;
    bit              mPend;
    bit              mArm;
    bit              mEndSeen;
    bit              mHaltSeen;
    bit              mOverrun;
    logic [NIRQ-1:0] mAck;
    logic [7:0]      mVector;

    cu_sequencer #(
        .T_PER_M       (T),
        .MAX_M         (MAXM),
        .NUM_IRQ       (NIRQ),
        .DISPATCH_M    (DISPM),
        .VECTOR_BASE   (VBASE),
        .VECTOR_STRIDE (VSTEP)
    ) dut (
        .i_Clk        (clk),
        .i_nRst       (nRst),
        .i_Enable     (enable),
        .i_End_Opcode (endOpcode),
        .i_Halt       (haltIn),
        .i_EI         (eiIn),
        .i_DI         (diIn),
        .i_RETI       (retiIn),
        .i_IRQ        (irqIn),
        .o_T_Step     (tStep),
        .o_M_Count    (mCount),
        .o_Fetch      (fetch),
        .o_Init       (init),
        .o_Dispatch   (dispatch),
        .o_Irq_Ack    (irqAck),
        .o_Vector     (vector),
        .o_IME        (ime),
        .o_Halted     (halted),
        .o_Overrun    (overrun)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic enterDispatch();
        int k;
        k = 0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (irqIn[i]) k = i;
        end
        mAck    = NIRQ'(1) << k;
        mVector = 8'(VBASE + k * VSTEP);
        mPhase  = P_DISP;
        mCyc    = 0;
    endtask

    task automatic modelStep();
        bit boundary;
        bit endNow;
        bit haltNow;
        bit nIme;
        bit nPend;
        bit nArm;
        if (!nRst) begin
            mPhase    = P_INIT;
            mCyc      = 0;
            mIme      = 0;
            mPend     = 0;
            mArm      = 0;
            mEndSeen  = 0;
            mHaltSeen = 0;
            mOverrun  = 0;
            mAck      = '0;
            mVector   = '0;
            return;
        end
        if (!enable) return;
        mAck = '0;
        case (mPhase)
            P_INIT: begin
                mCyc++;
                if (mCyc == T) begin
                    mPhase = P_FETCH;
                    mCyc   = 0;
                end
            end
            P_FETCH: begin
                if (mPend) begin
                    mArm  = 1;
                    mPend = 0;
                end
                mPhase = P_EXEC;
                mCyc   = 0;
            end
            P_EXEC: begin
                boundary = ((mCyc % T) == T - 1);
                endNow   = mEndSeen || endOpcode;
                haltNow  = mHaltSeen || haltIn;
                nIme     = mIme;
                nPend    = mPend;
                nArm     = mArm;
                if (diIn) begin
                    nIme  = 0;
                    nPend = 0;
                    nArm  = 0;
                end else if (retiIn) begin
                    nIme = 1;
                end else if (eiIn) begin
                    nPend = 1;
                end
                if (!boundary) begin
                    mEndSeen  = endNow;
                    mHaltSeen = haltNow;
                    mCyc++;
                end else begin
                    mEndSeen  = 0;
                    mHaltSeen = 0;
                    if (endNow) begin
                        if (nArm) begin
                            nIme = 1;
                            nArm = 0;
                        end
                        mCyc = 0;
                        if (nIme && irqIn != 0) begin
                            enterDispatch();
                            nIme = 0;
                        end else if (haltNow) begin
                            mPhase = P_HALT;
                        end else begin
                            mPhase = P_FETCH;
                        end
                    end else if (mCyc / T == MAXM - 1) begin
                        mOverrun = 1;
                        mPhase   = P_FETCH;
                        mCyc     = 0;
                    end else begin
                        mCyc++;
                    end
                end
                mIme  = nIme;
                mPend = nPend;
                mArm  = nArm;
            end
            P_HALT: begin
                if (irqIn != 0) begin
                    if (mIme) begin
                        enterDispatch();
                        mIme = 0;
                    end else begin
                        mPhase = P_FETCH;
                    end
                end
            end
            P_DISP: begin
                mCyc++;
                if (mCyc == DISPM * T) begin
                    mPhase = P_FETCH;
                    mCyc   = 0;
                end
            end
            default: mPhase = P_INIT;
        endcase
    endtask

    task automatic checkOutput();
        bit strobes;
        logic [31:0] expT;
        logic [31:0] expM;
        strobes = (mPhase == P_INIT) || (mPhase == P_EXEC) || (mPhase == P_DISP);
        expT = strobes ? (32'd1 << (mCyc % T)) : 32'd0;
        expM = strobes ? (32'd1 << (mCyc / T)) : 32'd0;
        check("T_Step",   32'(tStep),    expT);
        check("M_Count",  32'(mCount),   expM);
        check("Fetch",    32'(fetch),    32'(mPhase == P_FETCH));
        check("Init",     32'(init),     32'(mPhase == P_INIT));
        check("Dispatch", 32'(dispatch), 32'(mPhase == P_DISP));
        check("Halted",   32'(halted),   32'(mPhase == P_HALT));
        check("IME",      32'(ime),      32'(mIme));
        check("Overrun",  32'(overrun),  32'(mOverrun));
        check("Irq_Ack",  32'(irqAck),   32'(mAck));
        check("Vector",   32'(vector),   32'(mVector));
    endtask

    task automatic applyStimulus(input logic r, input logic en, input logic eo,
                                 input logic h, input logic e, input logic d,
                                 input logic ri, input logic [NIRQ-1:0] q);
        nRst      = r;
        enable    = en;
        endOpcode = eo;
        haltIn    = h;
        eiIn      = e;
        diIn      = d;
        retiIn    = ri;
        irqIn     = q;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    // Runs one opcode: lenM M-cycles long (0 = never ends), end flag on T-step endT.
    task automatic runOpcode(input int lenM, input int endT, input bit haltF,
                             input bit eiF, input bit diF, input bit retiF,
                             input logic [NIRQ-1:0] irqV);
        int  guard;
        bit  first;
        bit  endStep;
        guard = 0;
        while (mPhase != P_EXEC && guard < 40) begin
            applyStimulus(1, 1, 0, 0, 0, 0, 0, irqV);
            guard++;
        end
        guard = 0;
        while (mPhase == P_EXEC && guard < 64) begin
            first   = (mCyc == 0);
            endStep = (lenM > 0) && (mCyc / T == lenM - 1) && (mCyc % T == endT);
            applyStimulus(1, 1, endStep, endStep & haltF, first & eiF,
                          first & diF, first & retiF, irqV);
            guard++;
        end
        check("opcodeLeftExec", 32'(mPhase != P_EXEC), 32'd1);
    endtask

    task automatic drainDispatch(output int n);
        n = 0;
        while (dispatch === 1'b1 && n < 40) begin
            applyStimulus(1, 1, 0, 0, 0, 0, 0, '0);
            n++;
        end
    endtask

    initial begin
        int n;
        logic [NIRQ-1:0] rq;

        // Reset with enable low, then with enable high.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, '0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, '0);
        check("resetInit", 32'(init), 32'd1);

        // Post-reset prefetch, fetch, then opcode ending at m=1, t=2.
        runOpcode(2, 2, 0, 0, 0, 0, '0);
        check("endM1Fetch", 32'(fetch), 32'd1);

        // Enable IME with RETI, then dispatch IRQ pattern 10100.
        runOpcode(1, 3, 0, 0, 0, 1, '0);
        check("retiIme", 32'(ime), 32'd1);
        runOpcode(2, 1, 0, 0, 0, 0, 5'b10100);
        check("disp2Vector", 32'(vector), 32'h50);
        check("disp2Ack", 32'(irqAck), 32'b00100);
        check("disp2Ime", 32'(ime), 32'd0);
        drainDispatch(n);
        check("disp2Length", 32'(n), 32'(DISPM * T));
        check("disp2Fetch", 32'(fetch), 32'd1);

        // Delayed EI: no dispatch after the EI opcode, dispatch after the next.
        runOpcode(1, 0, 0, 1, 0, 0, 5'b00001);
        check("eiNoDispatch", 32'(fetch), 32'd1);
        runOpcode(1, 2, 0, 0, 0, 0, 5'b00001);
        check("eiDispatch", 32'(dispatch), 32'd1);
        check("eiVector", 32'(vector), 32'h40);
        drainDispatch(n);
        // Same again, but DI inside the following opcode cancels it.
        runOpcode(1, 1, 0, 1, 0, 0, 5'b00001);
        runOpcode(1, 2, 0, 0, 1, 0, 5'b00001);
        check("diNoDispatch", 32'(dispatch), 32'd0);
        check("diFetch", 32'(fetch), 32'd1);

        // HALT with IME=0, enable dropped mid-halt, wake on IRQ 1 without ack.
        runOpcode(1, 3, 1, 0, 0, 0, '0);
        check("haltEntered", 32'(halted), 32'd1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, (i < 3 || i > 5), 0, 0, 0, 0, 0, '0);
        end
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 5'b00010);
        check("haltWakeFetch", 32'(fetch), 32'd1);
        check("haltWakeNoAck", 32'(irqAck), 32'd0);

        // Opcode that never ends runs into the overrun limit.
        runOpcode(0, 0, 0, 0, 0, 0, '0);
        check("overrunFlag", 32'(overrun), 32'd1);
        check("overrunFetch", 32'(fetch), 32'd1);

        // Reset in the middle of a dispatch.
        runOpcode(1, 3, 0, 0, 0, 1, '0);
        runOpcode(1, 1, 0, 0, 0, 0, 5'b01000);
        for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 0, 0, 0, 0, '0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 5'b01000);
        check("rstInit", 32'(init), 32'd1);
        check("rstOverrun", 32'(overrun), 32'd0);
        check("rstIme", 32'(ime), 32'd0);
        check("rstDispatch", 32'(dispatch), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            rq = ($urandom_range(0, 2) == 0) ? NIRQ'($urandom) : '0;
            applyStimulus(($urandom_range(0, 299) != 0),
                          ($urandom_range(0, 9) != 0),
                          ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 29) == 0),
                          ($urandom_range(0, 19) == 0),
                          rq);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
